// File: rtl/nexys_starship_pkg.sv
// ============================================================================
// Module   : nexys_starship_pkg
// Brief    : Shared widths, defaults and one-hot FSM encodings for the GCD
//            request front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nexys_starship_pkg;

    localparam int c_DATA_W          = 8;
    localparam int c_DEPTH_DEFAULT   = 4;
    localparam int c_TIMEOUT_DEFAULT = 1024;

    localparam int c_ST_W = 6;
    localparam logic [c_ST_W-1:0] c_ST_IDLE   = 6'b000001;
    localparam logic [c_ST_W-1:0] c_ST_ISSUE  = 6'b000010;
    localparam logic [c_ST_W-1:0] c_ST_WAIT   = 6'b000100;
    localparam logic [c_ST_W-1:0] c_ST_ACK    = 6'b001000;
    localparam logic [c_ST_W-1:0] c_ST_RESULT = 6'b010000;
    localparam logic [c_ST_W-1:0] c_ST_ERR    = 6'b100000;

endpackage

`default_nettype wire

// File: rtl/nexys_starship_opq.sv
// ============================================================================
// Module   : nexys_starship_opq
// Brief    : DEPTH-entry synchronous FIFO holding packed {A,B} operand pairs,
//            head word presented combinationally.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nexys_starship_opq #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign full  = (r_count == c_FULL);
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/nexys_starship_gcd_req.sv
// ============================================================================
// Module   : nexys_starship_gcd_req
// Brief    : Queues operand pairs and sequences them through an external GCD
//            core; optional WAIT timeout via NEXYS_STARSHIP_GCD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nexys_starship_gcd_req
    import nexys_starship_pkg::*;
#(
    parameter int DEPTH   = c_DEPTH_DEFAULT,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                In_Valid,
    output logic                In_Ready,
    input  logic [c_DATA_W-1:0] In_A,
    input  logic [c_DATA_W-1:0] In_B,
    output logic [c_DATA_W-1:0] Ain,
    output logic [c_DATA_W-1:0] Bin,
    output logic                Start,
    output logic                Ack,
    input  logic                q_I,
    input  logic                q_Done,
    input  logic [c_DATA_W-1:0] AB_GCD,
    output logic                Res_Valid,
    input  logic                Res_Ready,
    output logic [c_DATA_W-1:0] Res_GCD,
    output logic [c_DATA_W-1:0] Res_A,
    output logic [c_DATA_W-1:0] Res_B,
    output logic                Busy,
    output logic                Err,
    output logic [c_DATA_W-1:0] Done_Count
);

    logic [c_ST_W-1:0]     r_state;
    logic [c_DATA_W-1:0]   r_op_a;
    logic [c_DATA_W-1:0]   r_op_b;
    logic [c_DATA_W-1:0]   r_res_gcd;
    logic [c_DATA_W-1:0]   r_done_count;
    logic [2*c_DATA_W-1:0] w_head;
    logic [c_DATA_W-1:0]   w_head_a;
    logic [c_DATA_W-1:0]   w_head_b;
    logic                  w_full;
    logic                  w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_timeout;

    assign w_push   = In_Valid && In_Ready;
    assign w_pop    = (r_state == c_ST_IDLE) && (w_count != '0);
    assign w_head_a = w_head[2*c_DATA_W-1:c_DATA_W];
    assign w_head_b = w_head[c_DATA_W-1:0];

    nexys_starship_opq #(
        .DEPTH (DEPTH),
        .WIDTH (2*c_DATA_W)
    ) u_opq (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({In_A, In_B}),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

`ifdef NEXYS_STARSHIP_GCD_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT) + 1;
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TIMEOUT - 1);

    logic [c_TW-1:0] r_wait_cnt;
    logic [c_TW-1:0] w_wait_nxt;

    // Timeout fires in the cycle whose count step would reach TIMEOUT-1.
    assign w_wait_nxt = r_wait_cnt + c_TW'(1);
    assign w_timeout  = !q_Done && (w_wait_nxt == c_TMO_LAST);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == c_ST_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == c_ST_WAIT) begin
            r_wait_cnt <= w_wait_nxt;
        end
    end

    assign Err = (r_state == c_ST_ERR);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
    assign Err              = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= c_ST_IDLE;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_res_gcd    <= '0;
            r_done_count <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_op_a <= w_head_a;
                        r_op_b <= w_head_b;
                        // gcd(x,0) = x, so a zero operand bypasses the core.
                        if ((w_head_a == '0) || (w_head_b == '0)) begin
                            r_res_gcd <= w_head_a | w_head_b;
                            r_state   <= c_ST_RESULT;
                        end else begin
                            r_state   <= c_ST_ISSUE;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    if (q_I) r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (q_Done) begin
                        r_res_gcd <= AB_GCD;
                        r_state   <= c_ST_ACK;
                    end else if (w_timeout) begin
                        r_state   <= c_ST_ERR;
                    end
                end
                c_ST_ACK: begin
                    r_state <= c_ST_RESULT;
                end
                c_ST_RESULT: begin
                    if (Res_Ready) begin
                        r_done_count <= r_done_count + c_DATA_W'(1);
                        r_state      <= c_ST_IDLE;
                    end
                end
`ifdef NEXYS_STARSHIP_GCD_TIMEOUT_EN
                c_ST_ERR: begin
                    r_state <= c_ST_ERR;
                end
`endif
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign In_Ready   = !w_full && !Err;
    assign Ain        = r_op_a;
    assign Bin        = r_op_b;
    assign Start      = (r_state == c_ST_ISSUE) && q_I;
    assign Ack        = (r_state == c_ST_ACK);
    assign Res_Valid  = (r_state == c_ST_RESULT);
    assign Res_GCD    = r_res_gcd;
    assign Res_A      = r_op_a;
    assign Res_B      = r_op_b;
    assign Busy       = (r_state != c_ST_IDLE) || !w_empty;
    assign Done_Count = r_done_count;

endmodule

`default_nettype wire

// File: tb/tb_nexys_starship_gcd_req.sv
// ============================================================================
// Module   : tb_nexys_starship_gcd_req
// Brief    : Directed self-checking bench with a behavioural GCD core model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nexys_starship_gcd_req;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       In_Valid = 1'b0;
    logic       In_Ready;
    logic [7:0] In_A = '0;
    logic [7:0] In_B = '0;
    logic [7:0] Ain;
    logic [7:0] Bin;
    logic       Start;
    logic       Ack;
    logic       q_I;
    logic       q_Done;
    logic [7:0] AB_GCD;
    logic       Res_Valid;
    logic       Res_Ready = 1'b0;
    logic [7:0] Res_GCD;
    logic [7:0] Res_A;
    logic [7:0] Res_B;
    logic       Busy;
    logic       Err;
    logic [7:0] Done_Count;

    always #5 Clk = ~Clk;

    nexys_starship_gcd_req #(
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .In_A       (In_A),
        .In_B       (In_B),
        .Ain        (Ain),
        .Bin        (Bin),
        .Start      (Start),
        .Ack        (Ack),
        .q_I        (q_I),
        .q_Done     (q_Done),
        .AB_GCD     (AB_GCD),
        .Res_Valid  (Res_Valid),
        .Res_Ready  (Res_Ready),
        .Res_GCD    (Res_GCD),
        .Res_A      (Res_A),
        .Res_B      (Res_B),
        .Busy       (Busy),
        .Err        (Err),
        .Done_Count (Done_Count)
    );

    // Behavioural GCD core: idle -> busy (3 cycles) -> done until Ack.
    int         never_done = 0;
    int         hold_after_ack = 0;
    logic [1:0] r_core_st;
    logic [3:0] r_core_hold;
    logic [3:0] r_core_cnt;
    logic [7:0] r_core_val;

    function automatic logic [7:0] gcd_f(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin t = x % y; x = y; y = t; end
        return x;
    endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_core_st <= 2'd0; r_core_hold <= '0; r_core_cnt <= '0; r_core_val <= '0;
        end else begin
            case (r_core_st)
                2'd0: begin
                    if (r_core_hold != 0) r_core_hold <= r_core_hold - 4'd1;
                    else if (Start) begin
                        r_core_val <= gcd_f(Ain, Bin);
                        r_core_cnt <= 4'd2;
                        r_core_st  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (never_done == 0) begin
                        if (r_core_cnt == 0) r_core_st <= 2'd2;
                        else r_core_cnt <= r_core_cnt - 4'd1;
                    end
                end
                default: begin
                    if (Ack) begin
                        r_core_st   <= 2'd0;
                        r_core_hold <= 4'(hold_after_ack);
                    end
                end
            endcase
        end
    end

    assign q_I    = (r_core_st == 2'd0) && (r_core_hold == 0);
    assign q_Done = (r_core_st == 2'd2);
    assign AB_GCD = r_core_val;

    // Event monitor, sampled on the rising edge before state updates land.
    int cyc = 0, start_cnt = 0, ack_cnt = 0, start_run = 0, max_run = 0;
    int viol = 0, last_start_cyc = 0, ack_cyc = 0, done_cyc = 0;
    logic qd_prev = 1'b0;

    always @(posedge Clk) begin
        cyc++;
        if (Start) begin
            start_cnt++;
            last_start_cyc = cyc;
            start_run++;
            if (start_run > max_run) max_run = start_run;
            if (!q_I) viol++;
        end else begin
            start_run = 0;
        end
        if (Ack) begin ack_cnt++; ack_cyc = cyc; end
        if (q_Done && !qd_prev) done_cyc = cyc;
        qd_prev = q_Done;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        In_Valid = 1'b1; In_A = a; In_B = b;
        @(negedge Clk);
        In_Valid = 1'b0;
    endtask

    task automatic take_result(input string tag, input logic [7:0] g,
                               input logic [7:0] a, input logic [7:0] b);
        int k;
        k = 0;
        while (!Res_Valid && k < 200) begin @(negedge Clk); k++; end
        check_eq({tag, "_valid"}, 32'(Res_Valid), 32'd1);
        check_eq({tag, "_gcd"}, 32'(Res_GCD), 32'(g));
        check_eq({tag, "_a"}, 32'(Res_A), 32'(a));
        check_eq({tag, "_b"}, 32'(Res_B), 32'(b));
        Res_Ready = 1'b1;
        @(negedge Clk);
        Res_Ready = 1'b0;
    endtask

    initial begin
        int s0, a0, ack1, k;
        @(negedge Clk);
        apply_reset();

        // Reset state
        check_eq("rst_in_ready", 32'(In_Ready), 32'd1);
        check_eq("rst_start", 32'(Start), 32'd0);
        check_eq("rst_ack", 32'(Ack), 32'd0);
        check_eq("rst_res_valid", 32'(Res_Valid), 32'd0);
        check_eq("rst_res_gcd", 32'(Res_GCD), 32'd0);
        check_eq("rst_done_count", 32'(Done_Count), 32'd0);
        check_eq("rst_err", 32'(Err), 32'd0);
        check_eq("rst_busy", 32'(Busy), 32'd0);

        // Basic pair through the core
        s0 = start_cnt; a0 = ack_cnt;
        push_pair(8'd12, 8'd18);
        take_result("p12_18", 8'd6, 8'd12, 8'd18);
        check_eq("p12_18_starts", 32'(start_cnt - s0), 32'd1);
        check_eq("p12_18_acks", 32'(ack_cnt - a0), 32'd1);
        check_eq("p12_18_ack_lat", 32'(ack_cyc - done_cyc), 32'd1);
        check_eq("p12_18_done_cnt", 32'(Done_Count), 32'd1);

        // Zero operands bypass the core
        s0 = start_cnt;
        push_pair(8'd0, 8'd9);
        take_result("p0_9", 8'd9, 8'd0, 8'd9);
        push_pair(8'd0, 8'd0);
        take_result("p0_0", 8'd0, 8'd0, 8'd0);
        check_eq("zero_no_start", 32'(start_cnt - s0), 32'd0);
        check_eq("zero_done_cnt", 32'(Done_Count), 32'd3);

        // Fill the queue behind a stalled result
        push_pair(8'd3, 8'd0);
        @(negedge Clk);
        check_eq("stall_valid", 32'(Res_Valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            In_Valid = 1'b1;
            case (i)
                0: begin In_A = 8'd12; In_B = 8'd18; end
                1: begin In_A = 8'd8;  In_B = 8'd4;  end
                2: begin In_A = 8'd9;  In_B = 8'd6;  end
                3: begin In_A = 8'd7;  In_B = 8'd5;  end
                default: begin In_A = 8'd15; In_B = 8'd10; end
            endcase
            if (i == 3) check_eq("fill_ready_4th", 32'(In_Ready), 32'd1);
            if (i == 4) check_eq("fill_full_5th", 32'(In_Ready), 32'd0);
            @(negedge Clk);
        end
        In_Valid = 1'b0;
        check_eq("stall_hold_gcd", 32'(Res_GCD), 32'd3);
        check_eq("stall_hold_a", 32'(Res_A), 32'd3);
        check_eq("stall_hold_b", 32'(Res_B), 32'd0);
        take_result("q0", 8'd3, 8'd3, 8'd0);
        take_result("q1", 8'd6, 8'd12, 8'd18);
        take_result("q2", 8'd4, 8'd8, 8'd4);
        take_result("q3", 8'd3, 8'd9, 8'd6);
        take_result("q4", 8'd1, 8'd7, 8'd5);
        repeat (10) @(negedge Clk);
        check_eq("drop5_no_valid", 32'(Res_Valid), 32'd0);
        check_eq("drop5_idle", 32'(Busy), 32'd0);
        check_eq("drain_ready", 32'(In_Ready), 32'd1);
        check_eq("drain_done_cnt", 32'(Done_Count), 32'd8);

        // Core keeps q_I low after Ack
        hold_after_ack = 5;
        s0 = start_cnt; viol = 0; max_run = 0;
        push_pair(8'd12, 8'd18);
        push_pair(8'd8, 8'd4);
        take_result("h1", 8'd6, 8'd12, 8'd18);
        ack1 = ack_cyc;
        take_result("h2", 8'd4, 8'd8, 8'd4);
        hold_after_ack = 0;
        check_eq("hold_starts", 32'(start_cnt - s0), 32'd2);
        check_eq("hold_no_early_start", 32'(viol), 32'd0);
        check_eq("hold_start_width", 32'(max_run), 32'd1);
        check_eq("hold_start_gap", 32'(last_start_cyc - ack1), 32'd6);

        // Reset while waiting on the core
        never_done = 1;
        push_pair(8'd12, 8'd18);
        k = 0;
        while (!Start && k < 50) begin @(negedge Clk); k++; end
        check_eq("rstw_start_seen", 32'(Start), 32'd1);
        repeat (4) @(negedge Clk);
        a0 = ack_cnt;
        Reset = 1'b1;
        @(negedge Clk);
        check_eq("rstw_res_valid", 32'(Res_Valid), 32'd0);
        check_eq("rstw_in_ready", 32'(In_Ready), 32'd1);
        check_eq("rstw_busy", 32'(Busy), 32'd0);
        check_eq("rstw_start", 32'(Start), 32'd0);
        check_eq("rstw_done_cnt", 32'(Done_Count), 32'd0);
        check_eq("rstw_res_a", 32'(Res_A), 32'd0);
        Reset = 1'b0;
        never_done = 0;
        @(negedge Clk);
        check_eq("rstw_no_ack", 32'(ack_cnt - a0), 32'd0);
        push_pair(8'd8, 8'd4);
        take_result("rstw_p8_4", 8'd4, 8'd8, 8'd4);

`ifdef NEXYS_STARSHIP_GCD_TIMEOUT_EN
        // Core never finishes: Err on the 16th WAIT cycle
        never_done = 1;
        push_pair(8'd12, 8'd18);
        k = 0;
        while (!Start && k < 50) begin @(negedge Clk); k++; end
        check_eq("to_start_seen", 32'(Start), 32'd1);
        repeat (15) @(negedge Clk);
        check_eq("to_err_early", 32'(Err), 32'd0);
        @(negedge Clk);
        check_eq("to_err", 32'(Err), 32'd1);
        check_eq("to_in_ready", 32'(In_Ready), 32'd0);
        check_eq("to_res_valid", 32'(Res_Valid), 32'd0);
        repeat (5) @(negedge Clk);
        check_eq("to_err_sticky", 32'(Err), 32'd1);
        check_eq("to_no_start", 32'(Start), 32'd0);
        check_eq("to_no_ack", 32'(Ack), 32'd0);
        apply_reset();
        never_done = 0;
        check_eq("to_err_cleared", 32'(Err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nexys_starship_gcd_req.md
NEXYS_STARSHIP_GCD_REQ -- requirements
Module: nexys_starship_gcd_req

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand-queue depth in entries (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 1024, cycle limit in WAIT; used only with NEXYS_STARSHIP_GCD_TIMEOUT_EN.
REQ-003 SHALL have clock Clk; reset Reset, asynchronous, active-high.
REQ-004 SHALL have ports, one per line:
- Clk  in  1  clock
- Reset  in  1  async active-high reset
- In_Valid  in  1  operand pair offered
- In_Ready  out  1  queue not full
- In_A, In_B  in  8 each  operands
- Ain, Bin  out  8 each  operands to GCD core
- Start  out  1  start to core
- Ack  out  1  acknowledge to core
- q_I  in  1  core in initial state
- q_Done  in  1  core in done state
- AB_GCD  in  8  core result
- Res_Valid  out  1  result available
- Res_Ready  in  1  result consumed
- Res_GCD, Res_A, Res_B  out  8 each  result and its operands
- Busy  out  1  FSM not IDLE or queue not empty
- Err  out  1  sticky timeout flag
- Done_Count  out  8  completed results, wraps 255->0

Function
REQ-005 SHALL accept a push when In_Valid && In_Ready at posedge; In_Ready = (count != DEPTH).
REQ-006 SHALL accept push and pop in the same cycle with count unchanged; push while full SHALL be ignored.
REQ-007 SHALL implement states IDLE, ISSUE, WAIT, ACK, RESULT, plus ERR when timeout is enabled.
REQ-008 IDLE: when count > 0, SHALL pop the head into Op_A/Op_B.
- If either operand is 0, SHALL go to RESULT with Res_GCD = Op_A | Op_B.
- Otherwise SHALL go to ISSUE.
REQ-009 Ain/Bin SHALL equal Op_A/Op_B from ISSUE entry until leaving ACK.
REQ-010 ISSUE: Start = q_I (combinational); SHALL go to WAIT on the edge where q_I = 1; otherwise SHALL stay.
REQ-011 Start SHALL be 0 in every state other than ISSUE.
REQ-012 WAIT: when q_Done = 1, SHALL capture AB_GCD into Res_GCD and go to ACK.
REQ-013 ACK: Ack = 1 for exactly one cycle, then RESULT; Ack SHALL be 0 elsewhere.
REQ-014 RESULT: Res_Valid = 1 with Res_A/Res_B = Op_A/Op_B.
- On Res_Ready, SHALL increment Done_Count and return to IDLE.
- Res_* SHALL hold stable while Res_Ready = 0.
REQ-015 A queued pair SHALL reach ISSUE no earlier than 2 cycles after its push edge; there SHALL be no bubble between RESULT handshake and next IDLE pop.
REQ-016 Next Start SHALL never be asserted before the core reports q_I after Ack.
REQ-017 All arithmetic SHALL be 8-bit unsigned; Done_Count SHALL wrap modulo 256.

Reset
REQ-018 On Reset, SHALL set:
- state IDLE; queue empty
- Op_A, Op_B, Res_GCD, Res_A, Res_B, Done_Count, Err = 0
- Start = Ack = Res_Valid = 0; In_Ready = 1
REQ-019 Reset mid-operation (any state) SHALL discard queue and in-flight pair with no Ack issued.

Configuration
REQ-020 With NEXYS_STARSHIP_GCD_TIMEOUT_EN defined:
- a wait counter SHALL clear on WAIT entry and count every WAIT cycle.
- On reaching TIMEOUT-1 without q_Done, SHALL go to ERR.
- ERR: Err = 1 sticky, Res_Valid = 0, In_Ready = 0, no Start/Ack, until Reset.
REQ-021 Without NEXYS_STARSHIP_GCD_TIMEOUT_EN:
- no counter and no ERR state; WAIT SHALL wait indefinitely.
- Err SHALL be tied 0.

Structure
REQ-022 Shared package nexys_starship_pkg SHALL hold state encodings (one-hot), data width 8 and default DEPTH/TIMEOUT constants.
REQ-023 The operand queue SHALL be a sub-module nexys_starship_opq (DEPTH x 16-bit synchronous FIFO with full/empty/count).

Verification
REQ-024 Push (12,18) with a behavioural GCD core -> one Start pulse, Ack one cycle after q_Done, Res_GCD=6, Res_A=12, Res_B=18, Done_Count=1.
REQ-025 Push (0,9), then (0,0) -> Res_GCD=9, then 0, with Start never asserted.
REQ-026 Push 5 pairs back-to-back with Res_Ready=0 -> In_Ready low after 4 in queue, 5th dropped; Res_* stable until Res_Ready=1.
REQ-027 Timeout enabled, TIMEOUT=16, core never asserts q_Done -> Err=1 on 16th WAIT cycle, In_Ready=0; holds until Reset.
REQ-028 Reset asserted in WAIT -> all outputs at reset values next cycle; subsequent push (8,4) -> Res_GCD=4.
REQ-029 Core holds q_I=0 for 5 cycles after Ack -> Start remains 0 until q_I=1, then a single-cycle Start.
